debounce_array: RTL and testbench



---
 rtl/debounce_array.sv | 103 ++++++++++
 tb/tb_debounce_array.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/debounce_array.sv
// debounce_array: multi-channel button debouncer with optional long-press detect.
//
// Each channel passes its raw input through an optional inversion, a 2-FF
// synchroniser and a symmetric debounce counter. Both press and release are
// filtered. Every channel is independent; all logic is on one clock.
//
// Optional build macro: LONG_PRESS_EN adds per-channel hold counters that
// drive long_press; without it, long_press is tied to 0.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   button         raw asynchronous inputs, bit i = channel i
//   level          debounced state, 1 = pressed
//   press          one-cycle pulse on level 0->1
//   release_pulse  one-cycle pulse on level 1->0 ("release" is a reserved word)
//   long_press     one-cycle pulse after LONG_CYCLES of continuous level=1
module debounce_array #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned STABLE_CYCLES = 50000,
  parameter logic        ACTIVE_LOW    = 1'b0,
  parameter int unsigned LONG_CYCLES   = 50000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] long_press
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic [CHANNELS-1:0] in_v;
  logic [CHANNELS-1:0] s1;
  logic [CHANNELS-1:0] s2;
  logic [CW-1:0]       cnt [CHANNELS];

  assign in_v = button ^ {CHANNELS{ACTIVE_LOW}};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1            <= '0;
      s2            <= '0;
      level         <= '0;
      press         <= '0;
      release_pulse <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1 <= in_v;
      s2 <= s1;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        press[i]         <= 1'b0;
        release_pulse[i] <= 1'b0;
        if (s2[i] == level[i]) begin
          // any return to the current level discards the partial count
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          cnt[i]           <= '0;
          level[i]         <= ~level[i];
          press[i]         <= ~level[i];
          release_pulse[i] <= level[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

`ifdef LONG_PRESS_EN
  localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

  logic [HW-1:0] hold [CHANNELS];

  // Hold counter saturates at HOLD_MAX so the pulse fires once per press.
  always_ff @(posedge clk) begin
    if (rst) begin
      long_press <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        hold[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        long_press[i] <= 1'b0;
        if (!level[i]) begin
          hold[i] <= '0;
        end else if (hold[i] != HOLD_MAX) begin
          hold[i]       <= hold[i] + HW'(1);
          long_press[i] <= (hold[i] == HOLD_MAX - HW'(1));
        end
      end
    end
  end
`else
  assign long_press = '0;
`endif

endmodule

// File: tb/tb_debounce_array.sv
// Scoreboard bench for debounce_array. Two instances: a 4-channel active-high
// one and a 1-channel active-low one (observed as bit 4 of each field).
// Expected pulse events (edge number plus pulse/level snapshot) are queued as
// stimulus is issued; a negedge monitor pops one whenever any pulse appears.
module tb_debounce_array;

  localparam int unsigned CH     = 4;
  localparam int unsigned STABLE = 4;
  localparam int unsigned LONG   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] button;
  logic [CH-1:0] level, press, rel, lp;
  logic          b_low;
  logic          lv_low, p_low, r_low, lp_low;

  always #5 clk = ~clk;

  debounce_array #(
    .CHANNELS(CH), .STABLE_CYCLES(STABLE), .ACTIVE_LOW(1'b0), .LONG_CYCLES(LONG)
  ) dut (
    .clk(clk), .rst(rst), .button(button), .level(level), .press(press),
    .release_pulse(rel), .long_press(lp)
  );

  debounce_array #(
    .CHANNELS(1), .STABLE_CYCLES(STABLE), .ACTIVE_LOW(1'b1), .LONG_CYCLES(LONG)
  ) dut_low (
    .clk(clk), .rst(rst), .button(b_low), .level(lv_low), .press(p_low),
    .release_pulse(r_low), .long_press(lp_low)
  );

  typedef struct {
    int         e;
    logic [19:0] v;  // {press, release, long_press, level}, 5 bits each
  } ev_t;

  ev_t         exp_q[$];
  ev_t         cur;
  int          edge_n = 0;
  int          checks = 0;
  int          errors = 0;
  logic        rst_q = 1'b0;
  logic [19:0] obs;

  assign obs = {p_low, press, r_low, rel, lp_low, lp, lv_low, level};

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    rst_q  <= rst;
  end

  always @(negedge clk) begin
    if (edge_n >= 1) begin
      if (rst_q) begin
        checks++;
        if (obs !== 20'h0) begin
          errors++;
          $display("FAIL reset_zero edge %0d got %h want 00000", edge_n, obs);
        end
      end else begin
        while (exp_q.size() > 0 && exp_q[0].e < edge_n) begin
          checks++;
          errors++;
          $display("FAIL missing_event edge %0d got none want %h at edge %0d",
                   edge_n, exp_q[0].v, exp_q[0].e);
          void'(exp_q.pop_front());
        end
        if (|obs[19:5]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse edge %0d got %h want none", edge_n, obs);
          end else begin
            cur = exp_q.pop_front();
            if (cur.e != edge_n || obs !== cur.v) begin
              errors++;
              $display("FAIL pulse_event edge %0d got %h want %h at edge %0d",
                       edge_n, obs, cur.v, cur.e);
            end
          end
        end
      end
    end
  end

  function automatic void push(int e, logic [4:0] p, logic [4:0] r,
                               logic [4:0] l, logic [4:0] lv);
    ev_t x;
    x.e = e;
    x.v = {p, r, l, lv};
    exp_q.push_back(x);
  endfunction

  // Long-press events exist only in the LONG_PRESS_EN build.
  function automatic void push_lp(int e, logic [4:0] l);
`ifdef LONG_PRESS_EN
    push(e, 5'h00, 5'h00, l, l);
`else
    if (e < 0) push(e, 5'h00, 5'h00, l, l);
`endif
  endfunction

  // Advance to 1 time unit after rising edge number k.
  task automatic go(input int k);
    while (edge_n < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst    = 1'b1;
    button = 4'hF;
    b_low  = 1'b1;
    // Buttons held through reset: fresh press 6 edges after the last reset edge.
    push(9, 5'h0F, 5'h00, 5'h00, 5'h0F);
    push_lp(17, 5'h0F);
    go(3);
    rst = 1'b0;

    go(14);
    button = 4'h0;
    push(20, 5'h00, 5'h0F, 5'h00, 5'h00);

    // Active-low channel: idle high, pressed low for 10 cycles.
    go(22);
    b_low = 1'b0;
    push(28, 5'h10, 5'h00, 5'h00, 5'h10);
    push_lp(36, 5'h10);
    go(32);
    b_low = 1'b1;
    push(38, 5'h00, 5'h10, 5'h00, 5'h00);

    // Clean press and release on channel 0.
    go(40);
    button = 4'h1;
    push(46, 5'h01, 5'h00, 5'h00, 5'h01);
    push_lp(54, 5'h01);
    go(56);
    button = 4'h0;
    push(62, 5'h00, 5'h01, 5'h00, 5'h00);

    // Bounce on channel 1: 1,1,1,0 then steady 1.
    go(64);
    button[1] = 1'b1;
    push(74, 5'h02, 5'h00, 5'h00, 5'h02);
    push_lp(82, 5'h02);
    go(67);
    button[1] = 1'b0;
    go(68);
    button[1] = 1'b1;
    go(84);
    button = 4'h0;
    push(90, 5'h00, 5'h02, 5'h00, 5'h00);

    // Short hold on channel 3: level high 7 cycles, no long press.
    go(92);
    button = 4'h8;
    push(98, 5'h08, 5'h00, 5'h00, 5'h08);
    go(99);
    button = 4'h0;
    push(105, 5'h00, 5'h08, 5'h00, 5'h00);

    // Long hold on channel 3: one long press, no repeat.
    go(108);
    button = 4'h8;
    push(114, 5'h08, 5'h00, 5'h00, 5'h08);
    push_lp(122, 5'h08);
    go(140);
    button = 4'h0;
    push(146, 5'h00, 5'h08, 5'h00, 5'h00);

    // Reset with channel 3 high and channel 0 at count 2.
    go(150);
    button = 4'h8;
    push(156, 5'h08, 5'h00, 5'h00, 5'h08);
    push_lp(164, 5'h08);
    go(160);
    button = 4'h9;
    go(164);
    rst = 1'b1;
    go(165);
    rst = 1'b0;
    push(171, 5'h09, 5'h00, 5'h00, 5'h09);
    push_lp(179, 5'h09);
    go(182);
    button = 4'h0;
    push(188, 5'h00, 5'h09, 5'h00, 5'h00);

    go(200);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_events got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
